axil_skid_slice: RTL and testbench

AXI4-Lite register slice that inserts one pipeline stage on each of the five channels (AW, W, B, AR, R) between an interconnect master port and an AXI4-Lite slave such as the on-chip AXI-Lite RAM.
- Breaks every combinational valid/ready/payload path so the slave can sit across a floorplan boundary or a timing-critical region.
- Sustains full throughput: one transfer per cycle per channel.
- Each channel is an independent two-entry skid buffer that can be individually bypassed.

---
 rtl/axil_skid_slice.sv | 154 +++++++++++++++
 tb/tb_axil_skid_slice.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_skid_slice.sv
// AXI4-Lite register slice: one independently bypassable two-entry skid
// buffer on each of the AW, W, B, AR and R channels.

module axil_skid_chan #(
    parameter int WIDTH  = 8,
    parameter bit REG_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    generate
        if (REG_EN) begin : g_reg
            logic [WIDTH-1:0] temp_data;
            logic             temp_valid;
            logic             accept;
            logic             load_out;

            assign accept   = in_valid && in_ready;
            // Output register may take new content when it is empty or draining.
            assign load_out = out_ready || !out_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    in_ready   <= 1'b0;
                    out_valid  <= 1'b0;
                    temp_valid <= 1'b0;
                end else begin
                    in_ready <= out_ready || (!temp_valid && (!out_valid || !in_valid));
                    if (load_out) begin
                        if (temp_valid) begin
                            out_valid  <= 1'b1;
                            temp_valid <= 1'b0;
                        end else begin
                            out_valid <= accept;
                        end
                    end else if (accept) begin
                        temp_valid <= 1'b1;
                    end
                end
            end

            // Payload carries no reset; it is only meaningful under its valid.
            always_ff @(posedge clk) begin
                if (load_out) begin
                    if (temp_valid) begin
                        out_data <= temp_data;
                    end else if (accept) begin
                        out_data <= in_data;
                    end
                end else if (accept) begin
                    temp_data <= in_data;
                end
            end
        end else begin : g_wire
            assign out_data  = in_data;
            assign out_valid = in_valid;
            assign in_ready  = out_ready;
        end
    endgenerate

endmodule

module axil_skid_slice #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter bit AW_REG_EN  = 1'b1,
    parameter bit W_REG_EN   = 1'b1,
    parameter bit B_REG_EN   = 1'b1,
    parameter bit AR_REG_EN  = 1'b1,
    parameter bit R_REG_EN   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    axil_skid_chan #(.WIDTH(ADDR_WIDTH + 3), .REG_EN(AW_REG_EN)) u_aw (
        .clk(clk), .rst(rst),
        .in_data({s_axil_awprot, s_axil_awaddr}), .in_valid(s_axil_awvalid), .in_ready(s_axil_awready),
        .out_data({m_axil_awprot, m_axil_awaddr}), .out_valid(m_axil_awvalid), .out_ready(m_axil_awready)
    );

    axil_skid_chan #(.WIDTH(DATA_WIDTH + STRB_WIDTH), .REG_EN(W_REG_EN)) u_w (
        .clk(clk), .rst(rst),
        .in_data({s_axil_wstrb, s_axil_wdata}), .in_valid(s_axil_wvalid), .in_ready(s_axil_wready),
        .out_data({m_axil_wstrb, m_axil_wdata}), .out_valid(m_axil_wvalid), .out_ready(m_axil_wready)
    );

    axil_skid_chan #(.WIDTH(2), .REG_EN(B_REG_EN)) u_b (
        .clk(clk), .rst(rst),
        .in_data(m_axil_bresp), .in_valid(m_axil_bvalid), .in_ready(m_axil_bready),
        .out_data(s_axil_bresp), .out_valid(s_axil_bvalid), .out_ready(s_axil_bready)
    );

    axil_skid_chan #(.WIDTH(ADDR_WIDTH + 3), .REG_EN(AR_REG_EN)) u_ar (
        .clk(clk), .rst(rst),
        .in_data({s_axil_arprot, s_axil_araddr}), .in_valid(s_axil_arvalid), .in_ready(s_axil_arready),
        .out_data({m_axil_arprot, m_axil_araddr}), .out_valid(m_axil_arvalid), .out_ready(m_axil_arready)
    );

    axil_skid_chan #(.WIDTH(DATA_WIDTH + 2), .REG_EN(R_REG_EN)) u_r (
        .clk(clk), .rst(rst),
        .in_data({m_axil_rresp, m_axil_rdata}), .in_valid(m_axil_rvalid), .in_ready(m_axil_rready),
        .out_data({s_axil_rresp, s_axil_rdata}), .out_valid(s_axil_rvalid), .out_ready(s_axil_rready)
    );

endmodule

// File: tb/tb_axil_skid_slice.sv
// Directed bench for axil_skid_slice: one fully registered instance and one
// with the R channel bypassed, both fed from the same stimulus.

module tb_axil_skid_slice;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [15:0] s_axil_awaddr = '0;
    logic [2:0]  s_axil_awprot = '0;
    logic        s_axil_awvalid = 1'b0;
    logic [31:0] s_axil_wdata = '0;
    logic [3:0]  s_axil_wstrb = '0;
    logic        s_axil_wvalid = 1'b0;
    logic        s_axil_bready = 1'b1;
    logic [15:0] s_axil_araddr = '0;
    logic [2:0]  s_axil_arprot = '0;
    logic        s_axil_arvalid = 1'b0;
    logic        s_axil_rready = 1'b1;
    logic        m_axil_awready = 1'b1;
    logic        m_axil_wready = 1'b1;
    logic [1:0]  m_axil_bresp = '0;
    logic        m_axil_bvalid = 1'b0;
    logic        m_axil_arready = 1'b1;
    logic [31:0] m_axil_rdata = '0;
    logic [1:0]  m_axil_rresp = '0;
    logic        m_axil_rvalid = 1'b0;

    logic        s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid;
    logic [1:0]  s_axil_bresp, s_axil_rresp;
    logic [31:0] s_axil_rdata;
    logic [15:0] m_axil_awaddr, m_axil_araddr;
    logic [2:0]  m_axil_awprot, m_axil_arprot;
    logic        m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready;
    logic [31:0] m_axil_wdata;
    logic [3:0]  m_axil_wstrb;

    logic        b_s_axil_awready, b_s_axil_wready, b_s_axil_bvalid, b_s_axil_arready, b_s_axil_rvalid;
    logic [1:0]  b_s_axil_bresp, b_s_axil_rresp;
    logic [31:0] b_s_axil_rdata;
    logic [15:0] b_m_axil_awaddr, b_m_axil_araddr;
    logic [2:0]  b_m_axil_awprot, b_m_axil_arprot;
    logic        b_m_axil_awvalid, b_m_axil_wvalid, b_m_axil_bready, b_m_axil_arvalid, b_m_axil_rready;
    logic [31:0] b_m_axil_wdata;
    logic [3:0]  b_m_axil_wstrb;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axil_skid_slice dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot), .s_axil_awvalid(s_axil_awvalid),
        .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
        .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot), .s_axil_arvalid(s_axil_arvalid),
        .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid),
        .s_axil_rready(s_axil_rready),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot), .m_axil_awvalid(m_axil_awvalid),
        .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb), .m_axil_wvalid(m_axil_wvalid),
        .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
        .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot), .m_axil_arvalid(m_axil_arvalid),
        .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp), .m_axil_rvalid(m_axil_rvalid),
        .m_axil_rready(m_axil_rready)
    );

    axil_skid_slice #(.R_REG_EN(1'b0)) dut_byp (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot), .s_axil_awvalid(s_axil_awvalid),
        .s_axil_awready(b_s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
        .s_axil_wready(b_s_axil_wready),
        .s_axil_bresp(b_s_axil_bresp), .s_axil_bvalid(b_s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot), .s_axil_arvalid(s_axil_arvalid),
        .s_axil_arready(b_s_axil_arready),
        .s_axil_rdata(b_s_axil_rdata), .s_axil_rresp(b_s_axil_rresp), .s_axil_rvalid(b_s_axil_rvalid),
        .s_axil_rready(s_axil_rready),
        .m_axil_awaddr(b_m_axil_awaddr), .m_axil_awprot(b_m_axil_awprot), .m_axil_awvalid(b_m_axil_awvalid),
        .m_axil_awready(m_axil_awready),
        .m_axil_wdata(b_m_axil_wdata), .m_axil_wstrb(b_m_axil_wstrb), .m_axil_wvalid(b_m_axil_wvalid),
        .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(b_m_axil_bready),
        .m_axil_araddr(b_m_axil_araddr), .m_axil_arprot(b_m_axil_arprot), .m_axil_arvalid(b_m_axil_arvalid),
        .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp), .m_axil_rvalid(m_axil_rvalid),
        .m_axil_rready(b_m_axil_rready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] valids();
        return {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, s_axil_bvalid, s_axil_rvalid};
    endfunction

    function automatic logic [4:0] readys();
        return {s_axil_awready, s_axil_wready, m_axil_bready, s_axil_arready, m_axil_rready};
    endfunction

    initial begin
        int sent, rcv, stall_acc, stall_low, bubbles;
        logic s_hs, m_hs, stall;

        // Reset held for 4 cycles with all downstream/upstream readies high.
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_valids", 64'(valids()), 64'h0);
            chk("rst_readys", 64'(readys()), 64'h0);
        end
        rst = 1'b0;
        #1;
        chk("rel_readys_first", 64'(readys()), 64'h0);
        chk("rel_valids_first", 64'(valids()), 64'h0);
        tick();
        chk("rel_readys_second", 64'(readys()), 64'h1f);
        chk("rel_valids_second", 64'(valids()), 64'h0);

        // Back-to-back AW+W stream with m-side always ready.
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        s_axil_awprot  = 3'b010;
        s_axil_wstrb   = 4'hf;
        for (int i = 0; i < 16; i++) begin
            s_axil_awaddr = 16'(i * 4);
            s_axil_wdata  = 32'ha5a5_0000 + 32'(i);
            tick();
            chk("stream_awvalid", 64'(m_axil_awvalid), 64'h1);
            chk("stream_awaddr", 64'(m_axil_awaddr), 64'(i * 4));
            chk("stream_awprot", 64'(m_axil_awprot), 64'h2);
            chk("stream_wvalid", 64'(m_axil_wvalid), 64'h1);
            chk("stream_wdata", 64'(m_axil_wdata), 64'(32'ha5a5_0000 + 32'(i)));
            chk("stream_wstrb", 64'(m_axil_wstrb), 64'hf);
            chk("stream_readys", 64'({s_axil_awready, s_axil_wready}), 64'h3);
        end
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        tick();
        chk("stream_drain", 64'({m_axil_awvalid, m_axil_wvalid}), 64'h0);

        // AR stream of 12 beats; m_axil_arready low for cycles 4..8.
        sent = 0; rcv = 0; stall_acc = 0; stall_low = 0; bubbles = 0;
        s_axil_arprot = 3'b101;
        for (int cyc = 0; cyc < 30; cyc++) begin
            stall = (cyc >= 4) && (cyc < 9);
            m_axil_arready = !stall;
            s_axil_arvalid = (sent < 12);
            s_axil_araddr  = 16'(16'h0100 + sent * 4);
            #1;
            s_hs = s_axil_arvalid && s_axil_arready;
            m_hs = m_axil_arvalid && m_axil_arready;
            if (m_hs) begin
                chk("skid_araddr", 64'(m_axil_araddr), 64'(16'h0100 + rcv * 4));
                chk("skid_arprot", 64'(m_axil_arprot), 64'h5);
                rcv++;
            end
            if (rcv > 0 && rcv < 12 && !m_axil_arvalid) bubbles++;
            if (stall) begin
                if (s_hs) stall_acc++;
                if (!s_axil_arready) stall_low++;
            end
            if (s_hs) sent++;
            tick();
        end
        s_axil_arvalid = 1'b0;
        m_axil_arready = 1'b1;
        chk("skid_delivered", 64'(rcv), 64'd12);
        chk("skid_stall_accepts", 64'(stall_acc), 64'd1);
        chk("skid_stall_ready_low", 64'(stall_low), 64'd4);
        chk("skid_bubbles", 64'(bubbles), 64'd0);

        // Reverse path: two R beats while s_axil_rready toggles.
        sent = 0; rcv = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            s_axil_rready = (cyc % 2 == 0);
            m_axil_rvalid = (sent < 2);
            m_axil_rdata  = (sent == 0) ? 32'h1234_5678 : 32'h9abc_def0;
            m_axil_rresp  = 2'b00;
            #1;
            s_hs = s_axil_rvalid && s_axil_rready;
            m_hs = m_axil_rvalid && m_axil_rready;
            if (s_hs) begin
                chk("rev_rdata", 64'(s_axil_rdata), (rcv == 0) ? 64'h1234_5678 : 64'h9abc_def0);
                chk("rev_rresp", 64'(s_axil_rresp), 64'h0);
                rcv++;
            end
            if (m_hs) sent++;
            tick();
        end
        m_axil_rvalid = 1'b0;
        s_axil_rready = 1'b1;
        chk("rev_delivered", 64'(rcv), 64'd2);
        tick();
        chk("rev_idle", 64'(s_axil_rvalid), 64'h0);

        // Single B response with SLVERR.
        m_axil_bvalid = 1'b1;
        m_axil_bresp  = 2'b10;
        tick();
        m_axil_bvalid = 1'b0;
        chk("b_valid", 64'(s_axil_bvalid), 64'h1);
        chk("b_resp", 64'(s_axil_bresp), 64'h2);
        tick();
        chk("b_idle", 64'(s_axil_bvalid), 64'h0);

        // Fill W to FULL, then reset mid-operation.
        m_axil_wready = 1'b0;
        s_axil_wvalid = 1'b1;
        s_axil_wdata  = 32'hdead_0001;
        tick();
        s_axil_wdata  = 32'hdead_0002;
        tick();
        s_axil_wvalid = 1'b0;
        chk("full_wready", 64'(s_axil_wready), 64'h0);
        chk("full_wvalid", 64'(m_axil_wvalid), 64'h1);
        chk("full_wdata", 64'(m_axil_wdata), 64'hdead_0001);
        rst = 1'b1;
        tick();
        chk("midrst_valids", 64'(valids()), 64'h0);
        chk("midrst_readys", 64'(readys()), 64'h0);
        rst = 1'b0;
        m_axil_wready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_no_stale", 64'(m_axil_wvalid), 64'h0);
            chk("midrst_wready", 64'(s_axil_wready), 64'h1);
        end

        // R bypass instance: combinational follow-through.
        m_axil_rvalid = 1'b1;
        m_axil_rdata  = 32'hcafe_f00d;
        m_axil_rresp  = 2'b01;
        s_axil_rready = 1'b0;
        #1;
        chk("byp_rvalid", 64'(b_s_axil_rvalid), 64'h1);
        chk("byp_rdata", 64'(b_s_axil_rdata), 64'hcafe_f00d);
        chk("byp_rresp", 64'(b_s_axil_rresp), 64'h1);
        chk("byp_rready_lo", 64'(b_m_axil_rready), 64'h0);
        s_axil_rready = 1'b1;
        m_axil_rdata  = 32'h0bad_beef;
        #1;
        chk("byp_rready_hi", 64'(b_m_axil_rready), 64'h1);
        chk("byp_rdata2", 64'(b_s_axil_rdata), 64'h0bad_beef);
        m_axil_rvalid = 1'b0;
        #1;
        chk("byp_rvalid_lo", 64'(b_s_axil_rvalid), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
